// File: rtl/register_formatter.sv
`default_nettype none
// ============================================================================
// Module  : register_formatter
// Brief   : Streams a 5-bit register index as ASCII text ('x' prefix plus
//           decimal digits), one character per valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module register_formatter #(
    parameter bit EMIT_PREFIX  = 1'b1,
    parameter bit LEADING_ZERO = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       trigger_in,
    input  logic [4:0] register_in,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       ascii_last,
    output logic       busy_flag,
    output logic       done_flag
);

    localparam logic [7:0] c_ASCII_X    = 8'h78;
    localparam logic [7:0] c_ASCII_ZERO = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_TENS   = 3'd2,
        ST_ONES   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     r_state;
    logic [1:0] r_tens;
    logic [3:0] r_ones;
    logic [7:0] r_ascii;
    logic       r_valid;
    logic       r_last;
    logic       r_done;

    logic [1:0] w_tens;
    logic [3:0] w_ones;

    function automatic logic [7:0] f_digit(input logic [3:0] d);
        return c_ASCII_ZERO | {4'b0000, d};
    endfunction

    // Split the index into tens/ones by range compare. Only the low nibble
    // of (reg - 10*tens) is needed, so subtract (10*tens mod 16) from reg[3:0].
    always_comb begin
        w_tens = 2'd0;
        w_ones = register_in[3:0];
        if (register_in >= 5'd30) begin
            w_tens = 2'd3;
            w_ones = register_in[3:0] - 4'd14;
        end else if (register_in >= 5'd20) begin
            w_tens = 2'd2;
            w_ones = register_in[3:0] - 4'd4;
        end else if (register_in >= 5'd10) begin
            w_tens = 2'd1;
            w_ones = register_in[3:0] - 4'd10;
        end
    end

    // Sequencer: each transition also loads the character for the state being
    // entered, so every output comes straight from a flop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
            r_tens  <= 2'd0;
            r_ones  <= 4'd0;
            r_ascii <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (trigger_in) begin
                        r_tens  <= w_tens;
                        r_ones  <= w_ones;
                        r_valid <= 1'b1;
                        if (EMIT_PREFIX) begin
                            r_state <= ST_PREFIX;
                            r_ascii <= c_ASCII_X;
                            r_last  <= 1'b0;
                        end else if (LEADING_ZERO || (w_tens != 2'd0)) begin
                            r_state <= ST_TENS;
                            r_ascii <= f_digit({2'b00, w_tens});
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= ST_ONES;
                            r_ascii <= f_digit(w_ones);
                            r_last  <= 1'b1;
                        end
                    end
                end
                ST_PREFIX: begin
                    if (ascii_ready) begin
                        if (LEADING_ZERO || (r_tens != 2'd0)) begin
                            r_state <= ST_TENS;
                            r_ascii <= f_digit({2'b00, r_tens});
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= ST_ONES;
                            r_ascii <= f_digit(r_ones);
                            r_last  <= 1'b1;
                        end
                    end
                end
                ST_TENS: begin
                    if (ascii_ready) begin
                        r_state <= ST_ONES;
                        r_ascii <= f_digit(r_ones);
                        r_last  <= 1'b1;
                    end
                end
                ST_ONES: begin
                    if (ascii_ready) begin
                        r_state <= ST_DONE;
                        r_ascii <= 8'h00;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ascii_out   = r_ascii;
    assign ascii_valid = r_valid;
    assign ascii_last  = r_last;
    assign done_flag   = r_done;
    assign busy_flag   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_register_formatter.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_formatter
// Brief   : Self-checking bench for register_formatter (default parameters on
//           instance A, no prefix / no leading zero on instance B).
// Revision: 1.0 - initial release
// ============================================================================
module tb_register_formatter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_trig, a_ready, a_valid, a_last, a_busy, a_done;
    logic [4:0] a_reg;
    logic [7:0] a_out;
    logic       b_trig, b_ready, b_valid, b_last, b_busy, b_done;
    logic [4:0] b_reg;
    logic [7:0] b_out;

    register_formatter u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(a_trig), .register_in(a_reg),
        .ascii_out(a_out), .ascii_valid(a_valid), .ascii_ready(a_ready),
        .ascii_last(a_last), .busy_flag(a_busy), .done_flag(a_done)
    );

    register_formatter #(.EMIT_PREFIX(1'b0), .LEADING_ZERO(1'b0)) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(b_trig), .register_in(b_reg),
        .ascii_out(b_out), .ascii_valid(b_valid), .ascii_ready(b_ready),
        .ascii_last(b_last), .busy_flag(b_busy), .done_flag(b_done)
    );

    int    n_cmp  = 0;
    int    n_fail = 0;
    string a_str  = "";
    string a_lst  = "";
    string b_str  = "";
    string b_lst  = "";
    int    a_dcnt = 0;
    int    b_dcnt = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [7];

    // Reference: text of the field computed directly from the decimal value.
    function automatic string model(input int r, input bit p, input bit lz);
        string s;
        s = p ? "x" : "";
        if (lz || r >= 10) s = $sformatf("%s%0d", s, r / 10);
        s = $sformatf("%s%0d", s, r % 10);
        return s;
    endfunction

    function automatic string last_pat(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = $sformatf("%s%0d", s, (i == n - 1) ? 1 : 0);
        return s;
    endfunction

    task automatic check_str(input string name, input string got, input string exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" required \"%s\"", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captures accepted characters, last flags and done pulses; also checks
    // that a stalled character is held stable on the next cycle.
    initial begin : mon_a
        logic       stall;
        logic [7:0] pout;
        logic       plast;
        stall = 1'b0; pout = 8'h00; plast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_cmp++;
                    if (!(a_valid === 1'b1 && a_out === pout && a_last === plast)) begin
                        n_fail++;
                        $display("FAIL stall_hold_a: valid=%b out=%h last=%b required valid=1 out=%h last=%b",
                                 a_valid, a_out, a_last, pout, plast);
                    end
                end
                if (a_valid && a_ready) begin
                    a_str = $sformatf("%s%c", a_str, a_out);
                    a_lst = $sformatf("%s%0d", a_lst, a_last);
                end
                if (a_done) a_dcnt++;
                stall = a_valid && !a_ready;
                pout  = a_out;
                plast = a_last;
            end
        end
    end

    initial begin : mon_b
        logic       stall;
        logic [7:0] pout;
        stall = 1'b0; pout = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_cmp++;
                    if (!(b_valid === 1'b1 && b_out === pout)) begin
                        n_fail++;
                        $display("FAIL stall_hold_b: valid=%b out=%h required valid=1 out=%h",
                                 b_valid, b_out, pout);
                    end
                end
                if (b_valid && b_ready) begin
                    b_str = $sformatf("%s%c", b_str, b_out);
                    b_lst = $sformatf("%s%0d", b_lst, b_last);
                end
                if (b_done) b_dcnt++;
                stall = b_valid && !b_ready;
                pout  = b_out;
            end
        end
    end

    // One-cycle trigger; returns just after the accepting edge.
    task automatic start(input bit sel, input logic [4:0] r);
        if (!sel) begin
            a_str = ""; a_lst = ""; a_dcnt = 0; a_reg = r; a_trig = 1'b1;
            tick();
            a_trig = 1'b0;
        end else begin
            b_str = ""; b_lst = ""; b_dcnt = 0; b_reg = r; b_trig = 1'b1;
            tick();
            b_trig = 1'b0;
        end
    endtask

    // Runs until done_flag (bounded), then checks text, last flags, done count.
    task automatic finish(input bit sel, input bit rnd, input string name, input string exp);
        int k;
        k = 0;
        while (k < 300 && (sel ? b_dcnt : a_dcnt) == 0) begin
            if (rnd) begin
                if (sel) b_ready = 1'($urandom_range(0, 1));
                else     a_ready = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        tick();
        check_int({name, "_done"}, sel ? b_dcnt : a_dcnt, 1);
        check_str(name, sel ? b_str : a_str, exp);
        check_str({name, "_last"}, sel ? b_lst : a_lst, last_pat(exp.len()));
    endtask

    task automatic check_beat(input string name, input bit cmp_out, input logic [7:0] eo,
                              input logic ev, input logic el, input logic eb, input logic ed);
        @(negedge clk);
        n_cmp++;
        if ((cmp_out && a_out !== eo) || a_valid !== ev || a_last !== el ||
            a_busy !== eb || a_done !== ed) begin
            n_fail++;
            $display("FAIL %s: out=%h valid=%b last=%b busy=%b done=%b required out=%h valid=%b last=%b busy=%b done=%b",
                     name, a_out, a_valid, a_last, a_busy, a_done, eo, ev, el, eb, ed);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pat [5];
        int r;
        bit sel;

        tbl[0] = '{5'd5,  "x05"};
        tbl[1] = '{5'd0,  "x00"};
        tbl[2] = '{5'd30, "x30"};
        tbl[3] = '{5'd9,  "x09"};
        tbl[4] = '{5'd10, "x10"};
        tbl[5] = '{5'd29, "x29"};
        tbl[6] = '{5'd19, "x19"};
        pat = '{1, 0, 0, 1, 1};

        rst_n = 1'b0;
        a_trig = 1'b0; a_reg = 5'd0; a_ready = 1'b1;
        b_trig = 1'b0; b_reg = 5'd0; b_ready = 1'b1;
        repeat (3) tick();
        check_int("reset_a", int'({a_out, a_valid, a_last, a_busy, a_done}), 0);
        check_int("reset_b", int'({b_out, b_valid, b_last, b_busy, b_done}), 0);
        rst_n = 1'b1;
        tick();

        // Cycle-accurate field for register 5 with ready held high.
        a_str = ""; a_lst = ""; a_dcnt = 0;
        a_reg = 5'd5; a_trig = 1'b1;
        check_beat("t1_pre",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; a_trig = 1'b0;
        check_beat("t1_x",    1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0);
        check_beat("t1_tens", 1'b1, 8'h30, 1'b1, 1'b0, 1'b1, 1'b0);
        check_beat("t1_ones", 1'b1, 8'h35, 1'b1, 1'b1, 1'b1, 1'b0);
        check_beat("t1_done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_beat("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_str("t1_text", a_str, "x05");
        check_int("t1_done_cnt", a_dcnt, 1);

        // Register 31 with ready pattern 1,0,0,1,1.
        start(1'b0, 5'd31);
        for (int i = 0; i < 5; i++) begin
            a_ready = 1'(pat[i]);
            tick();
        end
        finish(1'b0, 1'b0, "t2_stall31", "x31");

        // Table vectors on the default-parameter instance.
        for (int i = 0; i < 7; i++) begin
            start(1'b0, tbl[i].r);
            finish(1'b0, 1'b0, $sformatf("tbl_%0d", tbl[i].r), $sformatf("%s", tbl[i].exp));
        end

        // Full sweep on the no-prefix / no-leading-zero instance.
        for (int i = 0; i < 32; i++) begin
            start(1'b1, 5'(i));
            finish(1'b1, 1'b0, $sformatf("sweep_%0d", i), model(i, 1'b0, 1'b0));
            check_int($sformatf("sweep_val_%0d", i), b_str.atoi(), i);
        end

        // Second trigger while in TENS must be ignored.
        start(1'b0, 5'd20);
        tick();
        a_trig = 1'b1; a_reg = 5'd7;
        tick();
        a_trig = 1'b0;
        finish(1'b0, 1'b0, "retrig", "x20");
        repeat (10) tick();
        check_str("retrig_quiet", a_str, "x20");
        check_int("retrig_done_cnt", a_dcnt, 1);

        // Reset asserted in the middle of a long stall.
        a_ready = 1'b0;
        start(1'b0, 5'd19);
        repeat (10) tick();
        check_int("stall_pre_rst", int'({a_valid, a_out}), int'({1'b1, 8'h78}));
        #2;
        rst_n = 1'b0;
        #1;
        check_int("rst_async_valid", int'(a_valid), 0);
        check_int("rst_async_busy", int'(a_busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1;
        repeat (3) tick();
        check_int("rst_no_done", a_dcnt, 0);
        check_str("rst_no_text", a_str, "");
        start(1'b0, 5'd2);
        finish(1'b0, 1'b0, "after_rst", "x02");

        // Randomized fields with random backpressure on both instances.
        for (int i = 0; i < 40; i++) begin
            r   = int'($urandom_range(0, 31));
            sel = 1'($urandom_range(0, 1));
            start(sel, 5'(r));
            finish(sel, 1'b1, $sformatf("rand_%0d_%0d_%0d", i, sel, r),
                   model(r, !sel, !sel));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
